// File: rtl/sample_spp_framer.sv
// Frames a continuous sample stream into SPP-sample packets via a one-sample holding register,
// so tlast can be attached late (idle timeout closes a partial packet on the held sample).
module sample_spp_framer #(
  parameter int WIDTH           = 32,
  parameter int SR_SPP_ADDR     = 150,
  parameter int SR_TIMEOUT_ADDR = 151,
  parameter int SPP_DEFAULT     = 364
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             set_stb,
  input  logic [7:0]       set_addr,
  input  logic [31:0]      set_data,
  input  logic [WIDTH-1:0] i_tdata,
  input  logic             i_tvalid,
  output logic             i_tready,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tlast,
  output logic             o_tvalid,
  input  logic             o_tready,
  output logic [31:0]      pkt_count,
  output logic             timeout_flush
);

  localparam logic [7:0]  SPP_ADDR = 8'(SR_SPP_ADDR);
  localparam logic [7:0]  TMO_ADDR = 8'(SR_TIMEOUT_ADDR);
  localparam logic [15:0] SPP_RST  = 16'(SPP_DEFAULT);

  logic [WIDTH-1:0] data_p1;
  logic             vld_p1;
  logic             last_p1;
  logic [15:0]      cnt;
  logic [15:0]      idle;
  logic [15:0]      spp_reg;
  logic [15:0]      spp_act;
  logic [15:0]      timeout_reg;

  logic        accept;
  logic        out_hs;
  logic [15:0] spp_eff;
  logic [16:0] cnt_inc;
  logic [16:0] idle_inc;

  assign o_tdata  = data_p1;
  assign o_tlast  = last_p1;
  assign o_tvalid = vld_p1 & (last_p1 | i_tvalid);
  assign i_tready = ~clear & (~vld_p1 | (o_tvalid & o_tready));

  assign accept   = i_tvalid & i_tready;
  assign out_hs   = o_tvalid & o_tready;
  // The first sample of a packet uses the live SPP register; later ones use the latched copy.
  assign spp_eff  = (cnt == 16'd0) ? spp_reg : spp_act;
  assign cnt_inc  = {1'b0, cnt} + 17'd1;
  assign idle_inc = {1'b0, idle} + 17'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      spp_reg     <= SPP_RST;
      timeout_reg <= 16'd0;
    end else if (set_stb) begin
      if (set_addr == SPP_ADDR) spp_reg <= set_data[15:0];
      if (set_addr == TMO_ADDR) timeout_reg <= set_data[15:0];
    end
  end

  // Holding stage: accept -> p1 -> output
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_p1       <= '0;
      vld_p1        <= 1'b0;
      last_p1       <= 1'b0;
      cnt           <= 16'd0;
      idle          <= 16'd0;
      spp_act       <= SPP_RST;
      pkt_count     <= 32'd0;
      timeout_flush <= 1'b0;
    end else if (clear) begin
      vld_p1        <= 1'b0;
      last_p1       <= 1'b0;
      cnt           <= 16'd0;
      idle          <= 16'd0;
      pkt_count     <= 32'd0;
      timeout_flush <= 1'b0;
    end else begin
      timeout_flush <= 1'b0;
      if (out_hs && last_p1) pkt_count <= pkt_count + 32'd1;

      if (accept) begin
        data_p1 <= i_tdata;
        vld_p1  <= 1'b1;
        idle    <= 16'd0;
        if (cnt == 16'd0) spp_act <= spp_reg;
        if (cnt_inc >= {1'b0, spp_eff}) begin
          last_p1 <= 1'b1;
          cnt     <= 16'd0;
        end else begin
          last_p1 <= 1'b0;
          cnt     <= cnt_inc[15:0];
        end
      end else if (out_hs) begin
        vld_p1  <= 1'b0;
        last_p1 <= 1'b0;
        idle    <= 16'd0;
      end else if (vld_p1 && !last_p1 && !i_tvalid) begin
        // Idle with a partial packet held: close it once the timeout is reached.
        if (timeout_reg != 16'd0 && idle_inc >= {1'b0, timeout_reg}) begin
          last_p1       <= 1'b1;
          cnt           <= 16'd0;
          idle          <= 16'd0;
          timeout_flush <= 1'b1;
        end else begin
          idle <= idle_inc[15:0];
        end
      end else begin
        idle <= 16'd0;
      end
    end
  end

endmodule

// File: tb/tb_sample_spp_framer.sv
// Scoreboard bench for sample_spp_framer: stimulus pushes expected {tlast,data}, a monitor pops on each output handshake.
module tb_sample_spp_framer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clear = 1'b0;
  logic        set_stb = 1'b0;
  logic [7:0]  set_addr = 8'd0;
  logic [31:0] set_data = 32'd0;
  logic [31:0] i_tdata = 32'd0;
  logic        i_tvalid = 1'b0;
  logic        i_tready;
  logic [31:0] o_tdata;
  logic        o_tlast;
  logic        o_tvalid;
  logic        o_tready;
  logic [31:0] pkt_count;
  logic        timeout_flush;

  int tests = 0;
  int fails = 0;
  int flush_seen = 0;
  bit rnd_mode = 1'b0;
  bit ready_force = 1'b1;
  logic [32:0] sb[$];

  sample_spp_framer dut (
    .clk(clk), .reset_n(reset_n), .clear(clear),
    .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .i_tdata(i_tdata), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
    .pkt_count(pkt_count), .timeout_flush(timeout_flush)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1 o_tready = rnd_mode ? 1'($urandom_range(0, 1)) : ready_force;
  end
  initial o_tready = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: inputs change only at posedge+1, so negedge reflects the upcoming edge.
  always @(negedge clk) begin
    if (reset_n && timeout_flush) flush_seen++;
    if (reset_n && o_tvalid && o_tready) begin
      if (sb.size() == 0) begin
        check("unexpected_output", {31'd0, o_tlast, o_tdata}, 64'hFFFF_FFFF);
      end else begin
        logic [32:0] e;
        e = sb.pop_front();
        check("out_data", {32'd0, o_tdata}, {32'd0, e[31:0]});
        check("out_last", {63'd0, o_tlast}, {63'd0, e[32]});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [7:0] a, input logic [15:0] d);
    set_stb = 1'b1; set_addr = a; set_data = {16'd0, d};
    tick();
    set_stb = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, input bit last_exp, input bit push);
    bit ok;
    int guard;
    if (rnd_mode) repeat ($urandom_range(0, 1)) tick();
    if (push) sb.push_back({last_exp, d});
    i_tdata = d; i_tvalid = 1'b1;
    ok = 1'b0; guard = 0;
    while (!ok && guard < 200) begin
      @(negedge clk);
      ok = i_tready;
      tick();
      guard++;
    end
    if (!ok) check("send_timeout", 64'd0, 64'd1);
    i_tvalid = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while (sb.size() != 0 && guard < 500) begin tick(); guard++; end
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #12;
    @(negedge clk);
    check("rst_i_tready", {63'd0, i_tready}, 64'd1);
    check("rst_o_tvalid", {63'd0, o_tvalid}, 64'd0);
    check("rst_o_tlast", {63'd0, o_tlast}, 64'd0);
    check("rst_o_tdata", {32'd0, o_tdata}, 64'd0);
    check("rst_pkt_count", {32'd0, pkt_count}, 64'd0);
    check("rst_flush", {63'd0, timeout_flush}, 64'd0);
    reset_n = 1'b1;
    tick();

    // Test 1: SPP=4, samples 1..10; 10 will be closed by the timeout in test 2
    write_reg(8'd150, 16'd4);
    for (int k = 1; k <= 10; k++) send(k, (k % 4 == 0) || (k == 10), 1'b1);
    // Test 2: TIMEOUT=8 written right away; flush on the 8th idle edge
    write_reg(8'd151, 16'd8);
    repeat (6) begin
      @(negedge clk);
      check("held_o_tvalid", {63'd0, o_tvalid}, 64'd0);
      tick();
    end
    check("no_early_flush", 64'(flush_seen), 64'd0);
    tick();
    check("flush_pulse", {63'd0, timeout_flush}, 64'd1);
    check("flush_last", {63'd0, o_tlast}, 64'd1);
    tick();
    check("pkt_count_t2", {32'd0, pkt_count}, 64'd3);
    check("flush_once", 64'(flush_seen), 64'd1);
    write_reg(8'd151, 16'd0);
    drain();

    // Test 3: SPP=7, 1001 samples with random gaps and backpressure
    write_reg(8'd150, 16'd7);
    rnd_mode = 1'b1;
    for (int k = 0; k < 1001; k++) send(32'h1000 + k, ((k + 1) % 7 == 0), 1'b1);
    drain();
    rnd_mode = 1'b0;
    tick();
    check("pkt_count_t3", {32'd0, pkt_count}, 64'd3 + 64'd143);

    // Test 4: SPP=4, rewrite to 6 after the 2nd sample
    write_reg(8'd150, 16'd4);
    send(32'h2001, 1'b0, 1'b1);
    send(32'h2002, 1'b0, 1'b1);
    write_reg(8'd150, 16'd6);
    for (int k = 3; k <= 16; k++) send(32'h2000 + k, (k == 4) || (k == 10) || (k == 16), 1'b1);
    drain();

    // Test 5: clear while sample 3 of a 5-sample packet is held
    write_reg(8'd150, 16'd5);
    send(32'h3001, 1'b0, 1'b1);
    send(32'h3002, 1'b0, 1'b1);
    send(32'h3003, 1'b0, 1'b0);
    clear = 1'b1;
    @(negedge clk);
    check("clear_i_tready", {63'd0, i_tready}, 64'd0);
    tick();
    clear = 1'b0;
    @(negedge clk);
    check("clear_o_tvalid", {63'd0, o_tvalid}, 64'd0);
    check("clear_pkt_count", {32'd0, pkt_count}, 64'd0);
    tick();
    for (int k = 1; k <= 5; k++) send(32'h3100 + k, (k == 5), 1'b1);
    drain();
    check("pkt_count_t5", {32'd0, pkt_count}, 64'd1);

    // Test 6: async reset mid-packet with o_tvalid high
    ready_force = 1'b0;
    tick();
    send(32'h4001, 1'b0, 1'b0);
    i_tdata = 32'h4002; i_tvalid = 1'b1;
    @(negedge clk);
    check("pre_rst_o_tvalid", {63'd0, o_tvalid}, 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("async_o_tvalid", {63'd0, o_tvalid}, 64'd0);
    check("async_o_tlast", {63'd0, o_tlast}, 64'd0);
    check("async_pkt_count", {32'd0, pkt_count}, 64'd0);
    i_tvalid = 1'b0;
    ready_force = 1'b1;
    tick();
    reset_n = 1'b1;
    tick();
    flush_seen = 0;
    for (int k = 1; k <= 363; k++) send(32'h5000 + k, 1'b0, 1'b1);
    repeat (40) tick();
    @(negedge clk);
    check("t6_held_o_tvalid", {63'd0, o_tvalid}, 64'd0);
    check("t6_no_timeout", 64'(flush_seen), 64'd0);
    tick();
    send(32'h5000 + 364, 1'b1, 1'b1);
    drain();
    check("pkt_count_t6", {32'd0, pkt_count}, 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
